// File: rtl/fns_link_rx.sv
// FNS (Fibonacci numbering system) TSV link receiver: scans the fault map into
// per-wire weights, then decodes codewords and flags forbidden transitions.
module fns_link_rx #(
  parameter int unsigned NTSV = 9,
  parameter int unsigned DW   = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NTSV-1:0] f_flag,
  input  logic            cfg_load,
  output logic            cfg_busy,
  output logic [3:0]      n_enabled,
  input  logic [NTSV-1:0] tsv,
  input  logic            tsv_valid,
  output logic [DW-1:0]   dataout,
  output logic            out_valid,
  output logic            ftf_err,
  output logic [7:0]      fault_cnt
);

  localparam int unsigned WW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned IW = (NTSV > 1) ? $clog2(NTSV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [NTSV-1:0] r_flags;
  logic [WW-1:0]   r_weight [NTSV];
  logic [CW-1:0]   r_rank;
  logic [WW-1:0]   r_w1;
  logic [WW-1:0]   r_w2;
  logic            r_busy;
  logic [CW-1:0]   r_n_en;
  logic            r_s1_vld;
  logic [NTSV-1:0] r_s1_word;
  logic [NTSV-1:0] r_prev;
  logic            r_prev_vld;
  logic [DW-1:0]   r_dout;
  logic            r_out_vld;
  logic            r_ftf;
  logic [FW-1:0]   r_fault;

  logic [CW-1:0]   w_n_zero;
  logic [WW-1:0]   w_new_weight;
  logic [DW-1:0]   w_sum;
  logic            w_ftf;

  assign cfg_busy  = r_busy;
  assign n_enabled = r_n_en;
  assign dataout   = r_dout;
  assign out_valid = r_out_vld;
  assign ftf_err   = r_ftf;
  assign fault_cnt = r_fault;

  // Enabled-wire count taken from the incoming fault map at load time.
  always_comb begin
    w_n_zero = '0;
    for (int k = 0; k < int'(NTSV); k++) begin
      w_n_zero = w_n_zero + CW'(!f_flag[k]);
    end
  end

  // Fibonacci weight for the next enabled wire (1, 2, then sum of the last two).
  always_comb begin
    w_new_weight = WW'(r_w1 + r_w2);
    if (r_rank == CW'(0)) begin
      w_new_weight = WW'(1);
    end else if (r_rank == CW'(1)) begin
      w_new_weight = WW'(2);
    end
  end

  // Decoded value of the stage-1 word.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < int'(NTSV); k++) begin
      if (r_s1_word[k]) begin
        w_sum = w_sum + DW'(r_weight[k]);
      end
    end
  end

  // Forbidden transition between neighbouring enabled wires, skipping disabled ones.
  always_comb begin
    logic v_have;
    logic v_lp;
    logic v_lc;
    w_ftf  = 1'b0;
    v_have = 1'b0;
    v_lp   = 1'b0;
    v_lc   = 1'b0;
    for (int k = 0; k < int'(NTSV); k++) begin
      if (!r_flags[k]) begin
        if (v_have && ((!v_lp && r_prev[k] && v_lc && !r_s1_word[k]) ||
                       (v_lp && !r_prev[k] && !v_lc && r_s1_word[k]))) begin
          w_ftf = 1'b1;
        end
        v_have = 1'b1;
        v_lp   = r_prev[k];
        v_lc   = r_s1_word[k];
      end
    end
    w_ftf = w_ftf & r_prev_vld;
  end

  // Control FSM, weight scan and two-stage decode pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_flags    <= '0;
      for (int k = 0; k < int'(NTSV); k++) begin
        r_weight[k] <= '0;
      end
      r_rank     <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
      r_busy     <= 1'b0;
      r_n_en     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_word  <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_dout     <= '0;
      r_out_vld  <= 1'b0;
      r_ftf      <= 1'b0;
      r_fault    <= '0;
    end else begin
      r_out_vld <= 1'b0;
      if (cfg_load) begin
        // Reconfiguration drops any word in flight and forgets the previous word.
        r_state    <= ST_SCAN;
        r_idx      <= '0;
        r_flags    <= f_flag;
        for (int k = 0; k < int'(NTSV); k++) begin
          r_weight[k] <= '0;
        end
        r_rank     <= '0;
        r_w1       <= '0;
        r_w2       <= '0;
        r_busy     <= 1'b1;
        r_n_en     <= w_n_zero;
        r_s1_vld   <= 1'b0;
        r_s1_word  <= '0;
        r_prev     <= '0;
        r_prev_vld <= 1'b0;
        r_fault    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_SCAN: begin
            if (!r_flags[r_idx]) begin
              r_weight[r_idx] <= w_new_weight;
              r_w2            <= r_w1;
              r_w1            <= w_new_weight;
              r_rank          <= r_rank + CW'(1);
            end
            if (r_idx == IW'(NTSV - 1)) begin
              r_state <= ST_READY;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          ST_READY: begin
            r_s1_vld <= tsv_valid;
            if (tsv_valid) begin
              r_s1_word <= tsv & ~r_flags;
            end
            if (r_s1_vld) begin
              r_out_vld  <= 1'b1;
              r_dout     <= w_sum;
              r_ftf      <= w_ftf;
              r_prev     <= r_s1_word;
              r_prev_vld <= 1'b1;
              if (w_ftf && (r_fault != FW'(255))) begin
                r_fault <= r_fault + FW'(1);
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fns_link_rx.sv
// Directed bench for fns_link_rx: expected words are queued as they are driven
// and compared as the receiver emits them.
module tb_fns_link_rx;

  localparam int unsigned NTSV = 9;
  localparam int unsigned DW   = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NTSV-1:0] f_flag = '0;
  logic            cfg_load = 1'b0;
  logic            cfg_busy;
  logic [3:0]      n_enabled;
  logic [NTSV-1:0] tsv = '0;
  logic            tsv_valid = 1'b0;
  logic [DW-1:0]   dataout;
  logic            out_valid;
  logic            ftf_err;
  logic [7:0]      fault_cnt;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  logic [NTSV-1:0] m_ff   = '0;
  logic [NTSV-1:0] m_prev = '0;
  bit              m_pv   = 1'b0;
  int              m_fc   = 0;

  fns_link_rx #(.NTSV(NTSV), .DW(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .f_flag    (f_flag),
    .cfg_load  (cfg_load),
    .cfg_busy  (cfg_busy),
    .n_enabled (n_enabled),
    .tsv       (tsv),
    .tsv_valid (tsv_valid),
    .dataout   (dataout),
    .out_valid (out_valid),
    .ftf_err   (ftf_err),
    .fault_cnt (fault_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference decode: {ftf, data} for word w under fault map ff, previous word p.
  function automatic logic [DW:0] model(input logic [NTSV-1:0] ff, input logic [NTSV-1:0] w,
                                        input logic [NTSV-1:0] p, input bit pv);
    logic [NTSV-1:0] c;
    logic [DW-1:0]   d;
    logic            f;
    int a, b, wt, pos, last;
    c = w & ~ff;
    d = '0;
    f = 1'b0;
    a = 0; b = 0; pos = 0; last = -1;
    for (int k = 0; k < int'(NTSV); k++) begin
      if (!ff[k]) begin
        wt = (pos == 0) ? 1 : (pos == 1) ? 2 : a + b;
        b = a;
        a = wt;
        pos++;
        if (c[k]) d = d + DW'(wt);
        if (pv && last >= 0 && (p[last] !== p[k]) && (c[last] !== c[k]) && (p[last] === c[k]))
          f = 1'b1;
        last = k;
      end
    end
    return {f, d};
  endfunction

  task automatic send(input logic [NTSV-1:0] w, input bit acc);
    logic [DW:0] r;
    tsv       = w;
    tsv_valid = 1'b1;
    if (acc) begin
      r = model(m_ff, w, m_prev, m_pv);
      q.push_back('{d: r[DW-1:0], f: r[DW]});
      m_prev = w & ~m_ff;
      m_pv   = 1'b1;
      if (r[DW] && m_fc < 255) m_fc++;
    end
    cyc();
  endtask

  task automatic idle(input int n);
    tsv_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic drain();
    tsv_valid = 1'b0;
    for (int i = 0; i < 8 && q.size() != 0; i++) cyc();
    chk("drain_queue", 32'(q.size()), 32'd0);
  endtask

  task automatic cfg(input logic [NTSV-1:0] ff, input int exp_n);
    f_flag   = ff;
    cfg_load = 1'b1;
    cyc();
    cfg_load  = 1'b0;
    tsv_valid = 1'b0;
    m_ff = ff;
    m_pv = 1'b0;
    m_fc = 0;
    for (int i = 0; i < 9; i++) begin
      chk("cfg_busy_scan", 32'(cfg_busy), 32'd1);
      cyc();
    end
    chk("cfg_busy_done", 32'(cfg_busy), 32'd0);
    chk("n_enabled", 32'(n_enabled), 32'(exp_n));
    chk("fault_cnt_cleared", 32'(fault_cnt), 32'd0);
  endtask

  // Output monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("dataout", 32'(dataout), 32'(mon_e.d));
        chk("ftf_err", 32'(ftf_err), 32'(mon_e.f));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NTSV-1:0] rf;
    // Reset state
    repeat (2) cyc();
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_n_enabled", 32'(n_enabled), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ftf_err", 32'(ftf_err), 32'd0);
    chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
    reset_n = 1'b1;
    // IDLE ignores traffic
    send(9'h005, 1'b0);
    send(9'h0F0, 1'b0);
    idle(3);
    chk("idle_cfg_busy", 32'(cfg_busy), 32'd0);

    // All wires good, first word latency
    cfg(9'h000, 9);
    send(9'b000000101, 1'b1);
    tsv_valid = 1'b0;
    chk("lat_capture_edge", 32'(out_valid), 32'd0);
    cyc();
    chk("lat_next_edge", 32'(out_valid), 32'd1);
    chk("lat_dataout", 32'(dataout), 32'd4);
    drain();

    // Wire 1 disabled, masking and hold
    cfg(9'b000000010, 8);
    send(9'b000001101, 1'b1);
    send(9'b000000011, 1'b1);
    drain();
    chk("masked_dataout", 32'(dataout), 32'd1);
    idle(3);
    chk("hold_out_valid", 32'(out_valid), 32'd0);
    chk("hold_dataout", 32'(dataout), 32'd1);
    chk("hold_ftf_err", 32'(ftf_err), 32'd0);

    // Forbidden transition on adjacent wires
    cfg(9'h000, 9);
    send(9'b000000001, 1'b1);
    send(9'b000000010, 1'b1);
    drain();
    chk("ftf_adjacent", 32'(ftf_err), 32'd1);
    chk("ftf_fault_cnt", 32'(fault_cnt), 32'd1);

    // Disabled wire makes wires 0 and 2 neighbours
    cfg(9'b000000010, 8);
    send(9'b000000001, 1'b1);
    send(9'b000000100, 1'b1);
    drain();
    chk("ftf_skip_disabled", 32'(ftf_err), 32'd1);
    cfg(9'h000, 9);
    send(9'b000000001, 1'b1);
    send(9'b000000100, 1'b1);
    drain();
    chk("ftf_non_adjacent", 32'(ftf_err), 32'd0);

    // All wires faulty
    cfg(9'h1FF, 0);
    send(9'h1FF, 1'b1);
    send(9'h0AA, 1'b1);
    drain();
    chk("all_faulty_dataout", 32'(dataout), 32'd0);

    // cfg_load drops the concurrent word and flushes stage 1
    cfg(9'h000, 9);
    send(9'b000000011, 1'b1);
    send(9'b000000001, 1'b1);
    drain();
    send(9'h0F0, 1'b0);
    tsv = 9'h00F;
    cfg(9'h000, 9);
    send(9'b000000010, 1'b1);
    drain();
    chk("post_flush_ftf", 32'(ftf_err), 32'd0);

    // Saturating fault counter
    for (int i = 0; i < 260; i++) send((i % 2 == 0) ? 9'b000000001 : 9'b000000010, 1'b1);
    drain();
    chk("fault_cnt_saturated", 32'(fault_cnt), 32'd255);

    // Random fault map and traffic with gaps
    rf = NTSV'($urandom);
    cfg(rf, 9 - $countones(rf));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) send(NTSV'($urandom), 1'b1);
      else idle(1);
    end
    drain();
    chk("random_fault_cnt", 32'(fault_cnt), 32'(m_fc));

    // Asynchronous reset mid-scan
    f_flag   = 9'h000;
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    repeat (3) cyc();
    chk("midscan_busy", 32'(cfg_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(cfg_busy), 32'd0);
    chk("async_rst_n_enabled", 32'(n_enabled), 32'd0);
    chk("async_rst_dataout", 32'(dataout), 32'd0);
    chk("async_rst_fault_cnt", 32'(fault_cnt), 32'd0);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send(9'h005, 1'b0);
    idle(3);
    chk("post_rst_busy", 32'(cfg_busy), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    cfg(9'h000, 9);
    send(9'b000000101, 1'b1);
    drain();
    chk("post_rst_dataout", 32'(dataout), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
